// File: rtl/pll_loop_filter_pkg.sv
// Shared PLL definitions: loop-filter FSM states and a signed saturating adder
// used by this loop filter and the other PLL stages.
package pll_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        APPLY = 2'd2
    } lf_state_t;

    // Saturates a+b to the symmetric range +/-(2^(width-1)-1).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 width
    );
        logic signed [32:0] s;
        logic signed [32:0] lim;
        logic signed [32:0] nlim;
        s    = {a[31], a} + {b[31], b};
        lim  = (33'sd1 <<< (width - 1)) - 33'sd1;
        nlim = -lim;
        if (s > lim) begin
            sat_add = lim[31:0];
        end else if (s < nlim) begin
            sat_add = nlim[31:0];
        end else begin
            sat_add = s[31:0];
        end
    endfunction

endpackage

// File: rtl/pll_loop_filter_if.sv
// Loop-filter bus: PFD pulses, window strobe and hold in; control word and
// status out.
interface pll_loop_filter_if #(
    parameter int CW_W = 10
);
    logic            up;
    logic            down;
    logic            sample;
    logic            hold;
    logic [CW_W-1:0] ctrl_word;
    logic            ctrl_valid;
    logic            sat;
    logic            locked;
    logic            overrun;

    modport master (
        output up, down, sample, hold,
        input  ctrl_word, ctrl_valid, sat, locked, overrun
    );

    modport slave (
        input  up, down, sample, hold,
        output ctrl_word, ctrl_valid, sat, locked, overrun
    );
endinterface

// File: rtl/pll_loop_filter_lock_detect.sv
// Lock detector: counts consecutive in-tolerance window errors on each update
// strobe; locked follows the strobe in the same cycle as ctrl_valid.
module pll_lock_detect #(
    parameter int ERR_W    = 8,
    parameter int LOCK_TOL = 1,
    parameter int LOCK_CNT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_update,
    input  logic signed [ERR_W-1:0] i_err_q,
    output logic                    o_locked
);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_locked;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic signed [ERR_W-1:0] w_abs;
    logic                    w_in_tol;

    always_comb begin
        w_abs     = i_err_q[ERR_W-1] ? -i_err_q : i_err_q;
        w_in_tol  = (w_abs <= ERR_W'(LOCK_TOL));
        w_cnt_nxt = (r_cnt == CNT_W'(LOCK_CNT)) ? r_cnt : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (i_update) begin
            if (w_in_tol) begin
                r_cnt    <= w_cnt_nxt;
                r_locked <= (w_cnt_nxt == CNT_W'(LOCK_CNT));
            end else begin
                r_cnt    <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    assign o_locked = r_locked;
endmodule

// File: rtl/pll_loop_filter.sv
// Digital PI loop filter: integrates PFD pulse widths per window and turns each
// window error into a saturated oscillator control word.
//  state | meaning
//  ACCUM | integrating PFD pulses, waiting for sample strobe
//  CALC  | proportional term and integrator update from captured error
//  APPLY | clamp sum into ctrl_word, pulse ctrl_valid, update lock
module pll_loop_filter
    import pll_pkg::*;
#(
    parameter int ERR_W     = 8,
    parameter int CW_W      = 10,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 0,
    parameter int CW_CENTER = 512,
    parameter int LOCK_TOL  = 1,
    parameter int LOCK_CNT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pll_loop_filter_if.slave lf
);
    localparam int INT_W  = CW_W + 2;
    localparam int CW_MAX = (2 ** CW_W) - 1;

    lf_state_t r_state;
    lf_state_t w_state_nxt;

    logic                    w_capture;
    logic                    w_do_calc;
    logic                    w_do_apply;
    logic                    w_overrun_set;
    logic signed [1:0]       w_contrib;
    logic signed [ERR_W-1:0] r_err_acc;
    logic signed [ERR_W-1:0] r_err_q;
    logic signed [INT_W-1:0] r_integ;
    logic signed [INT_W-1:0] r_prop;
    logic signed [31:0]      w_sum;
    logic [CW_W-1:0]         w_cw_nxt;
    logic                    w_clamp;
    logic [CW_W-1:0]         r_ctrl_word;
    logic                    r_ctrl_valid;
    logic                    r_sat;
    logic                    r_overrun;
    logic                    w_locked;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (lf.sample) w_state_nxt = CALC;
            CALC:    w_state_nxt = APPLY;
            APPLY:   w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        w_capture     = (r_state == ACCUM) && lf.sample;
        w_do_calc     = (r_state == CALC);
        w_do_apply    = (r_state == APPLY);
        w_overrun_set = (r_state != ACCUM) && lf.sample;
    end

    always_comb begin
        w_contrib = 2'sd0;
        if (lf.up && !lf.down) begin
            w_contrib = 2'sd1;
        end else if (lf.down && !lf.up) begin
            w_contrib = -2'sd1;
        end
    end

    // Pulse in the sample cycle opens the new window rather than closing the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_acc <= '0;
            r_err_q   <= '0;
        end else if (w_capture) begin
            r_err_q   <= r_err_acc;
            r_err_acc <= ERR_W'(w_contrib);
        end else begin
            r_err_acc <= ERR_W'(sat_add(32'(r_err_acc), 32'(w_contrib), ERR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_integ <= '0;
            r_prop  <= '0;
        end else if (w_do_calc) begin
            r_prop <= INT_W'(sat_add(32'(r_err_q) <<< KP_SHIFT, 32'sd0, INT_W));
            if (!lf.hold) begin
                r_integ <= INT_W'(sat_add(32'(r_integ), 32'(r_err_q) <<< KI_SHIFT, INT_W));
            end
        end
    end

    always_comb begin
        w_sum    = 32'(CW_CENTER) + 32'(r_integ) + 32'(r_prop);
        w_cw_nxt = w_sum[CW_W-1:0];
        w_clamp  = 1'b0;
        if (w_sum < 32'sd0) begin
            w_cw_nxt = '0;
            w_clamp  = 1'b1;
        end else if (w_sum > 32'(CW_MAX)) begin
            w_cw_nxt = '1;
            w_clamp  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_word  <= CW_W'(CW_CENTER);
            r_ctrl_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_ctrl_valid <= w_do_apply;
            r_overrun    <= w_overrun_set;
            if (w_do_apply) begin
                r_ctrl_word <= w_cw_nxt;
                r_sat       <= w_clamp;
            end
        end
    end

    pll_lock_detect #(
        .ERR_W    (ERR_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_update (w_do_apply),
        .i_err_q  (r_err_q),
        .o_locked (w_locked)
    );

    assign lf.ctrl_word  = r_ctrl_word;
    assign lf.ctrl_valid = r_ctrl_valid;
    assign lf.sat        = r_sat;
    assign lf.locked     = w_locked;
    assign lf.overrun    = r_overrun;
endmodule

// File: tb/tb_pll_loop_filter.sv
// Self-checking bench for pll_loop_filter: a behavioural PI model queues the
// expected control word per accepted window; each scenario task pops and compares.
module tb_pll_loop_filter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pll_loop_filter_if #(.CW_W(10)) lf_bus ();

    pll_loop_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lf    (lf_bus)
    );

    typedef struct {
        int cw;
        bit sat;
        bit locked;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int m_err, m_errq, m_integ, m_busy, m_lock_cnt;
    int n_valid = 0;
    int n_ovr   = 0;

    always @(negedge clk) begin
        if (lf_bus.ctrl_valid === 1'b1) n_valid++;
        if (lf_bus.overrun === 1'b1) n_ovr++;
    end

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_err      = 0;
        m_errq     = 0;
        m_integ    = 0;
        m_busy     = 0;
        m_lock_cnt = 0;
        sb.delete();
    endtask

    // One clock: drive at negedge, advance the model at posedge, return at next negedge.
    task automatic cyc(input bit u, input bit d, input bit s, input bit h);
        int   c, prop, sum;
        exp_t e;
        lf_bus.up     = u;
        lf_bus.down   = d;
        lf_bus.sample = s;
        lf_bus.hold   = h;
        @(posedge clk);
        c = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_busy == 2) begin
                prop = clampi(m_errq * 4, -2047, 2047);
                if (!h) m_integ = clampi(m_integ + m_errq, -2047, 2047);
                sum   = 512 + m_integ + prop;
                e.cw  = clampi(sum, 0, 1023);
                e.sat = (sum < 0) || (sum > 1023);
                if (m_errq >= -1 && m_errq <= 1) m_lock_cnt = (m_lock_cnt < 8) ? m_lock_cnt + 1 : 8;
                else m_lock_cnt = 0;
                e.locked = (m_lock_cnt >= 8);
                sb.push_back(e);
            end
            if (s && m_busy == 0) begin
                m_errq = m_err;
                m_err  = c;
                m_busy = 2;
            end else begin
                m_err = clampi(m_err + c, -127, 127);
                if (m_busy > 0) m_busy--;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok, input bit h);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lf_bus.ctrl_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1'b0, 1'b0, 1'b0, h);
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit have);
        have = (sb.size() > 0);
        if (have) e = sb.pop_front();
        else begin
            e.cw = 512; e.sat = 1'b0; e.locked = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (lf_bus.ctrl_word !== 10'd512) begin
            errors++; $display("FAIL reset_ctrl_word got %0d want 512", lf_bus.ctrl_word);
        end
        checks++;
        if ({lf_bus.ctrl_valid, lf_bus.locked, lf_bus.sat, lf_bus.overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got valid/locked/sat/ovr=%b want 0000",
                     {lf_bus.ctrl_valid, lf_bus.locked, lf_bus.sat, lf_bus.overrun});
        end
    endtask

    task automatic test_prop_integ();
        exp_t e; bit have;
        do_reset();
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lf_bus.ctrl_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early got valid=%b want 0", lf_bus.ctrl_valid);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lf_bus.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL latency_n3 got valid=%b want 1", lf_bus.ctrl_valid);
        end
        pop_exp(e, have);
        checks++;
        if (!have || lf_bus.ctrl_word !== 10'(e.cw) || lf_bus.sat !== e.sat) begin
            errors++;
            $display("FAIL prop_integ got cw=%0d sat=%b want cw=%0d sat=%b (queued=%0d)",
                     lf_bus.ctrl_word, lf_bus.sat, e.cw, e.sat, have);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lf_bus.ctrl_valid !== 1'b0 || lf_bus.ctrl_word !== 10'(e.cw)) begin
            errors++;
            $display("FAIL valid_pulse_hold got valid=%b cw=%0d want valid=0 cw=%0d",
                     lf_bus.ctrl_valid, lf_bus.ctrl_word, e.cw);
        end
    endtask

    task automatic test_hold();
        exp_t e; bit have, ok;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            repeat (10) cyc(1'b0, 1'b1, 1'b0, pass[0]);
            cyc(1'b0, 1'b0, 1'b1, pass[0]);
            wait_valid(ok, pass[0]);
            pop_exp(e, have);
            checks++;
            if (!ok || !have || lf_bus.ctrl_word !== 10'(e.cw) || lf_bus.sat !== e.sat) begin
                errors++;
                $display("FAIL hold_pass%0d got cw=%0d sat=%b valid_seen=%b want cw=%0d sat=%b",
                         pass, lf_bus.ctrl_word, lf_bus.sat, ok, e.cw, e.sat);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_saturation();
        exp_t e; bit have, ok;
        do_reset();
        repeat (200) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(ok, 1'b0);
        pop_exp(e, have);
        checks++;
        if (!ok || !have || lf_bus.ctrl_word !== 10'(e.cw) || lf_bus.sat !== e.sat) begin
            errors++;
            $display("FAIL sat_high got cw=%0d sat=%b valid_seen=%b want cw=%0d sat=%b",
                     lf_bus.ctrl_word, lf_bus.sat, ok, e.cw, e.sat);
        end
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(ok, 1'b0);
        pop_exp(e, have);
        checks++;
        if (!ok || !have || lf_bus.ctrl_word !== 10'(e.cw) || lf_bus.sat !== e.sat) begin
            errors++;
            $display("FAIL sat_release got cw=%0d sat=%b valid_seen=%b want cw=%0d sat=%b",
                     lf_bus.ctrl_word, lf_bus.sat, ok, e.cw, e.sat);
        end
    endtask

    task automatic test_lock();
        exp_t e; bit have, ok;
        do_reset();
        for (int w = 0; w < 8; w++) begin
            repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            wait_valid(ok, 1'b0);
            pop_exp(e, have);
            checks++;
            if (!ok || !have || lf_bus.locked !== e.locked || lf_bus.ctrl_word !== 10'(e.cw)) begin
                errors++;
                $display("FAIL lock_win%0d got locked=%b cw=%0d want locked=%b cw=%0d",
                         w, lf_bus.locked, lf_bus.ctrl_word, e.locked, e.cw);
            end
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(ok, 1'b0);
        pop_exp(e, have);
        checks++;
        if (!ok || !have || lf_bus.locked !== e.locked || lf_bus.ctrl_word !== 10'(e.cw)) begin
            errors++;
            $display("FAIL lock_loss got locked=%b cw=%0d want locked=%b cw=%0d",
                     lf_bus.locked, lf_bus.ctrl_word, e.locked, e.cw);
        end
    endtask

    task automatic test_overrun_reset();
        exp_t e; bit have, ok;
        int n0, o0;
        do_reset();
        n0 = n_valid;
        o0 = n_ovr;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (lf_bus.overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_pulse got %b want 1", lf_bus.overrun);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lf_bus.overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_width got %b want 0", lf_bus.overrun);
        end
        wait_valid(ok, 1'b0);
        pop_exp(e, have);
        checks++;
        if (!ok || !have || lf_bus.ctrl_word !== 10'(e.cw)) begin
            errors++;
            $display("FAIL overrun_word got cw=%0d valid_seen=%b want cw=%0d",
                     lf_bus.ctrl_word, ok, e.cw);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ((n_valid - n0) !== 1 || (n_ovr - o0) !== 1) begin
            errors++;
            $display("FAIL overrun_counts got valid=%0d ovr=%0d want valid=1 ovr=1",
                     n_valid - n0, n_ovr - o0);
        end
        n0 = n_valid;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ((n_valid - n0) !== 0 || lf_bus.ctrl_word !== 10'd512 || sb.size() !== 0) begin
            errors++;
            $display("FAIL reset_in_apply got valid_pulses=%0d cw=%0d queued=%0d want 0 512 0",
                     n_valid - n0, lf_bus.ctrl_word, sb.size());
        end
    endtask

    initial begin
        lf_bus.up     = 1'b0;
        lf_bus.down   = 1'b0;
        lf_bus.sample = 1'b0;
        lf_bus.hold   = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_prop_integ();
        test_hold();
        test_saturation();
        test_lock();
        test_overrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
